dmem_responder: RTL

- Data-memory target for the pipeline's memory stage. It is the responder end of the load/store request interface that memory_access drives.
- Accepts one 64-bit load or store per handshake. Stalls the requester for a programmable latency, then returns read data or an error status.
- Supplies dmem_error for the M-stage status, and the data-memory side of M_valM.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: one 64-bit little-endian load/store per
// handshake, answered after a fixed latency with read data or a range error.
module dmem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_error_o,
  output logic        busy_o
);

  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [64:0]   LIMIT      = 65'(DEPTH_BYTES);
  localparam logic [CW-1:0] CNT_INIT   = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(1);
  localparam bit            ONE_CYCLE  = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH_BYTES];
  logic          lat_write;
  logic [63:0]   lat_addr;
  logic [63:0]   lat_wdata;
  logic [CW-1:0] cnt;

  logic          cur_write;
  logic          cur_error;
  logic          go_resp;
  logic [63:0]   cur_addr;
  logic [63:0]   cur_wdata;
  logic [63:0]   rd_word;
  logic [63:0]   resp_word;
  logic [64:0]   end_addr;
  logic [AW-1:0] base;

  // In IDLE the live request drives the single-cycle path; otherwise the latched copy.
  always_comb begin
    if (state == IDLE) begin
      cur_write = req_write_i;
      cur_addr  = req_addr_i;
      cur_wdata = req_wdata_i;
    end else begin
      cur_write = lat_write;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
    end
    // 65-bit sum so addresses near 2^64 cannot wrap back into range.
    end_addr  = {1'b0, cur_addr} + 65'd8;
    cur_error = (end_addr > LIMIT);
    base      = cur_addr[AW-1:0];
    go_resp   = ((state == IDLE) && req_valid_i && ONE_CYCLE) ||
                ((state == WAIT) && (cnt == CNT_LAST));
    rd_word   = 64'd0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[base + AW'(i)];
    end
    resp_word = (cur_write || cur_error) ? 64'd0 : rd_word;
  end

  // Store commit on the RESP entry edge; storage itself is never reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && go_resp && cur_write && !cur_error) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= cur_wdata[8*i +: 8];
      end
    end
  end

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_write    <= 1'b0;
      lat_addr     <= 64'd0;
      lat_wdata    <= 64'd0;
      req_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= 64'd0;
      resp_error_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            lat_write   <= req_write_i;
            lat_addr    <= req_addr_i;
            lat_wdata   <= req_wdata_i;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (ONE_CYCLE) begin
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_error_o <= cur_error;
              resp_rdata_o <= resp_word;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state        <= RESP;
            cnt          <= '0;
            resp_valid_o <= 1'b1;
            resp_error_o <= cur_error;
            resp_rdata_o <= resp_word;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_error_o <= 1'b0;
            resp_rdata_o <= 64'd0;
          end
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          req_ready_o  <= 1'b1;
          busy_o       <= 1'b0;
          resp_valid_o <= 1'b0;
          resp_error_o <= 1'b0;
          resp_rdata_o <= 64'd0;
        end
      endcase
    end
  end

endmodule
